redirect_ctrl: RTL and testbench
================================

# redirect_ctrl

Front-end redirect controller. Collects flush/redirect requests from up to NREQ pipeline stages (Decode2, the later decode stages, branch resolution, exception), picks the deepest requester, and delivers one word-aligned redirect to fetch over a valid/ready handshake. It drives per-stage squash lines and a front-end stall until fetch has accepted the redirect and the drain window has expired.

## Interface
- WIDTH, 32, address width.
- NREQ, 4, number of requesters. Index 0 is the shallowest stage (Decode2 flush_out). Higher index means a deeper stage and higher priority.
- HOLD_CYCLES, 2, drain cycles after fetch accepts. Legal range 0..15.

- clk  in  1  clock. One clock domain; rising edge.
- rst  in  1  reset. Asynchronous and active-high.
- clk_en  in  1  global enable. When low, all state and outputs hold.
- req_valid  in  NREQ  per-stage redirect request, level, sampled each enabled cycle.
- req_addr  in  NREQ×WIDTH  per-stage target address.
- redirect_valid  out  1  redirect offered to fetch.
- redirect_addr  out  WIDTH  target with bits [1:0] forced to 0.
- redirect_ready  in  1  fetch accepts the redirect when this and redirect_valid are both high.
- stage_flush  out  NREQ  squash line per stage. Bit j is high for every j ≤ the active winner index.
- busy  out  1  front-end stall. High whenever state ≠ IDLE.

## Operation
- States: IDLE, SEND, DRAIN. Registers: state, win_idx (log2 NREQ bits), addr, cnt (4 bits).
- Winner is the highest set index of req_valid. Let the candidate be that index, call it w.
- **IDLE**
  - Any req_valid set: next state SEND, win_idx←w, addr←req_addr[w]&~3.
- **SEND**
  - redirect_valid=1.
  - If a request with w > win_idx is present, replace win_idx/addr. This applies even in the accepting cycle; the newer value wins and the state stays SEND.
  - Requests with w ≤ win_idx are ignored; they come from stages already squashed.
  - On handshake with no replacement:
    - HOLD_CYCLES=0: go to IDLE.
    - Otherwise: go to DRAIN with cnt←HOLD_CYCLES.
- **DRAIN**
  - redirect_valid=0. stage_flush held at the current win_idx mask.
  - cnt decrements each enabled cycle; when cnt==1, go to IDLE next.
  - A request with w > win_idx goes to SEND with a new win_idx/addr.
  - A request with w ≤ win_idx is ignored.
- **Outputs**
  - All outputs are registered, decoded from state/win_idx/addr.
  - stage_flush = 0 in IDLE. In SEND and DRAIN it is the mask ((2<<win_idx)-1).
- **clk_en=0**: no transition, no handshake consumed. redirect_valid stays high if it was high. Fetch must not count an acceptance while clk_en is low.
- **Reset (async, any state)**
  - state=IDLE, win_idx=0, addr=0, cnt=0.
  - redirect_valid=0, redirect_addr=0, stage_flush=0, busy=0.
  - A pending redirect is discarded.

## Timing
- Request in enabled cycle N: redirect_valid, stage_flush and busy rise in cycle N+1. Latency is 1.
- Handshake in cycle M with HOLD_CYCLES=H>0: DRAIN occupies cycles M+1..M+H, IDLE is reached at M+H+1, and busy falls at M+H+1.
- Handshake in cycle M with H=0: IDLE at M+1.
- redirect_addr is stable while redirect_valid is high, except for a deeper-stage replacement, which takes effect one cycle after that request.
- Simultaneous requests: the highest index wins and the rest are dropped. The controller does not queue requests.
- A request arriving in the cycle cnt reaches 1:
  - Deeper than win_idx: goes to SEND, taking priority over the return to IDLE.
  - Otherwise: the controller returns to IDLE and re-arbitrates from the next cycle if the request is still held.

## Test plan
- **Single request.** NREQ=4, H=2, req_valid=0001, req_addr=0x1006 at cycle 0, ready=1 at cycle 1.
  - Cycle 1: redirect_valid=1, addr=0x1004, stage_flush=0001, busy=1.
  - Cycles 2–3: DRAIN.
  - Cycle 4: IDLE, busy=0.
- **Priority.** req_valid=0101 with addr[2]=0x2000 and addr[0]=0x3000 → redirect_addr=0x2000, stage_flush=0111.
- **Replacement.** Hold ready=0. Cycle 0: req 0 at 0x100. Cycle 2: req 3 at 0x400.
  - Cycle 3: redirect_addr=0x400, stage_flush=1111.
  - A later req 1 changes nothing.
- **Backpressure and clk_en.** ready=0 for 5 cycles → valid/addr held constant. clk_en=0 with ready=1 → no state change. Acceptance happens on the next enabled cycle.
- **H=0.** Handshake at cycle M → IDLE and busy=0 at M+1. A new request at M+1 gives SEND at M+2.
- **Reset mid-DRAIN.** rst asserted asynchronously with cnt=1 → all outputs 0 immediately. After release with no requests, the controller stays IDLE.

Source files
------------

// File: rtl/redirect_ctrl.sv
// Front-end redirect controller: arbitrates flush/redirect requests by stage depth,
// offers one word-aligned redirect to fetch and holds squash/stall through a drain window.
module redirect_ctrl #(
  parameter int WIDTH       = 32,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_addr,
  output logic                    redirect_valid,
  output logic [WIDTH-1:0]        redirect_addr,
  input  logic                    redirect_ready,
  output logic [NREQ-1:0]         stage_flush,
  output logic                    busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);
  localparam logic [WIDTH-1:0] ALIGN = {{(WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    win_idx, win_nx, cand;
  logic [WIDTH-1:0] addr, addr_nx, cand_addr;
  logic [3:0]       cnt, cnt_nx;
  logic [NREQ-1:0]  flush_nx;
  logic             any, deeper;

  // Deepest requester wins; later loop iterations override shallower ones.
  always_comb begin
    cand = '0;
    for (int j = 0; j < NREQ; j++)
      if (req_valid[j]) cand = IW'(j);
  end

  assign any       = |req_valid;
  assign deeper    = any && (cand > win_idx);
  assign cand_addr = req_addr[cand*WIDTH +: WIDTH] & ALIGN;

  always_comb begin
    state_nx = state;
    win_nx   = win_idx;
    addr_nx  = addr;
    cnt_nx   = cnt;
    if (clk_en) begin
      case (state)
        IDLE: begin
          if (any) begin
            state_nx = SEND;
            win_nx   = cand;
            addr_nx  = cand_addr;
          end
        end
        SEND: begin
          // A deeper replacement beats a same-cycle acceptance.
          if (deeper) begin
            win_nx  = cand;
            addr_nx = cand_addr;
          end else if (redirect_ready) begin
            if (HOLD_CYCLES == 0) begin
              state_nx = IDLE;
            end else begin
              state_nx = DRAIN;
              cnt_nx   = HOLD;
            end
          end
        end
        DRAIN: begin
          if (deeper) begin
            state_nx = SEND;
            win_nx   = cand;
            addr_nx  = cand_addr;
            cnt_nx   = '0;
          end else if (cnt <= 4'd1) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Squash mask covers every stage at or shallower than the winner.
  for (genvar j = 0; j < NREQ; j++) begin : g_flush
    assign flush_nx[j] = (state_nx != IDLE) && (win_nx >= IW'(j));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      win_idx        <= '0;
      addr           <= '0;
      cnt            <= '0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      stage_flush    <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nx;
      win_idx        <= win_nx;
      addr           <= addr_nx;
      cnt            <= cnt_nx;
      redirect_valid <= (state_nx == SEND);
      redirect_addr  <= addr_nx;
      stage_flush    <= flush_nx;
      busy           <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Randomized bench for redirect_ctrl: two instances (HOLD_CYCLES=2 and 0) checked
// against a pending/drain-countdown reference model plus directed scenarios.
module tb_redirect_ctrl;
  localparam int W = 32;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_en;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_addr;
  logic            redirect_ready;
  logic [1:0]      rv, bz;
  logic [W-1:0]    ra [2];
  logic [N-1:0]    sf [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending offer flag, drain cycles remaining, winner, target.
  int       hv   [2] = '{2, 0};
  bit       pend [2];
  int       dl   [2];
  int       win  [2];
  logic [W-1:0] tgt [2];

  always #5 clk = ~clk;

  redirect_ctrl #(.WIDTH(W), .NREQ(N), .HOLD_CYCLES(2)) u_h2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_addr(req_addr),
    .redirect_valid(rv[0]), .redirect_addr(ra[0]), .redirect_ready(redirect_ready),
    .stage_flush(sf[0]), .busy(bz[0]));

  redirect_ctrl #(.WIDTH(W), .NREQ(N), .HOLD_CYCLES(0)) u_h0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_addr(req_addr),
    .redirect_valid(rv[1]), .redirect_addr(ra[1]), .redirect_ready(redirect_ready),
    .stage_flush(sf[1]), .busy(bz[1]));

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; dl[d] = 0; win[d] = 0; tgt[d] = '0;
    end
  endtask

  task automatic model_step();
    int w;
    bit any;
    any = (req_valid != 0);
    w = 0;
    for (int j = 0; j < N; j++) if (req_valid[j]) w = j;
    if (!clk_en) return;
    for (int d = 0; d < 2; d++) begin
      if (pend[d]) begin
        if (any && w > win[d]) begin
          win[d] = w; tgt[d] = req_addr[w*W +: W] & ~32'd3;
        end else if (redirect_ready) begin
          pend[d] = 0; dl[d] = hv[d];
        end
      end else if (dl[d] > 0) begin
        if (any && w > win[d]) begin
          pend[d] = 1; dl[d] = 0; win[d] = w; tgt[d] = req_addr[w*W +: W] & ~32'd3;
        end else begin
          dl[d] = dl[d] - 1;
        end
      end else if (any) begin
        pend[d] = 1; win[d] = w; tgt[d] = req_addr[w*W +: W] & ~32'd3;
      end
    end
  endtask

  task automatic compare();
    bit b;
    for (int d = 0; d < 2; d++) begin
      b = pend[d] || (dl[d] > 0);
      chk($sformatf("valid%0d", d), W'(rv[d]), W'(pend[d]));
      chk($sformatf("busy%0d", d), W'(bz[d]), W'(b));
      chk($sformatf("flush%0d", d), W'(sf[d]), b ? W'((2 << win[d]) - 1) : '0);
      if (pend[d]) chk($sformatf("addr%0d", d), ra[d], tgt[d]);
    end
  endtask

  // Inputs are set at the falling edge before calling; outputs checked at the next one.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_req(input logic [N-1:0] v, input int idx, input logic [W-1:0] a);
    req_valid = v;
    if (idx >= 0) req_addr[idx*W +: W] = a;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; req_valid = '0; req_addr = '0; redirect_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", W'(rv[0]), '0);
    chk("rst_busy", W'(bz[0]), '0);
    chk("rst_flush", W'(sf[0]), '0);
    chk("rst_addr", ra[0], '0);
    @(negedge clk); rst = 1'b0;

    // Single request: aligned address, latency 1, two drain cycles.
    set_req(4'b0001, 0, 32'h1006);
    step();
    set_req(4'b0000, -1, '0); redirect_ready = 1'b1;
    chk("single_addr", ra[0], 32'h1004);
    chk("single_flush", W'(sf[0]), 32'h1);
    step();
    redirect_ready = 1'b0;
    chk("single_drain1", W'({bz[0], rv[0]}), 32'h2);
    chk("h0_idle", W'(bz[1]), '0);
    step();
    chk("single_drain2", W'({bz[0], rv[0]}), 32'h2);
    step();
    chk("single_idle", W'(bz[0]), '0);

    // Priority between simultaneous requests.
    req_addr[2*W +: W] = 32'h2000; req_addr[0 +: W] = 32'h3000;
    set_req(4'b0101, -1, '0);
    step();
    set_req(4'b0000, -1, '0);
    chk("prio_addr", ra[0], 32'h2000);
    chk("prio_flush", W'(sf[0]), 32'h7);
    redirect_ready = 1'b1; step(); redirect_ready = 1'b0;
    repeat (3) step();

    // Replacement by a deeper stage, then a shallower request is ignored.
    set_req(4'b0001, 0, 32'h100); step();
    set_req(4'b0000, -1, '0); step();
    set_req(4'b1000, 3, 32'h400); step();
    set_req(4'b0000, -1, '0);
    chk("repl_addr", ra[0], 32'h400);
    chk("repl_flush", W'(sf[0]), 32'hF);
    set_req(4'b0010, 1, 32'h777); step();
    set_req(4'b0000, -1, '0);
    chk("repl_keep", ra[0], 32'h400);
    // Backpressure, then clk_en low with ready high must not accept.
    repeat (5) step();
    chk("bp_valid", W'(rv[0]), 32'h1);
    clk_en = 1'b0; redirect_ready = 1'b1;
    repeat (3) step();
    chk("en_hold", W'(rv[0]), 32'h1);
    clk_en = 1'b1; step(); redirect_ready = 1'b0;
    chk("en_accept", W'(rv[0]), '0);
    // Request right after an H=0 acceptance.
    chk("h0_free", W'(bz[1]), '0);
    set_req(4'b0010, 1, 32'h55); step();
    set_req(4'b0000, -1, '0);
    chk("h0_resend", W'(rv[1]), 32'h1);
    redirect_ready = 1'b1; step(); redirect_ready = 1'b0;
    repeat (3) step();

    // Asynchronous reset while the H=2 instance sits at cnt==1.
    set_req(4'b0100, 2, 32'h9000); step();
    set_req(4'b0000, -1, '0); redirect_ready = 1'b1; step();
    redirect_ready = 1'b0; step();
    chk("pre_rst_drain", W'(dl[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", W'(bz[0]), '0);
    chk("arst_flush", W'(sf[0]), '0);
    chk("arst_addr", ra[0], '0);
    @(negedge clk); rst = 1'b0;
    repeat (4) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      clk_en = ($urandom_range(0, 99) < 85);
      redirect_ready = $urandom_range(0, 1);
      req_valid = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      for (int j = 0; j < N; j++) req_addr[j*W +: W] = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
